// File: rtl/crossbar_route_committer_if.sv
// APB requester/completer bundle for the crossbar route committer.
interface crossbar_route_committer_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [31:0]           pwdata;
  logic [31:0]           prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/crossbar_route_committer.sv
// Pushes dirty shadow muxsel entries to the crossbar matrix over APB, one transfer at a time.
// Optional read-back verify of each write: define CROSSBAR_COMMIT_VERIFY_EN.
module crossbar_route_committer #(
  parameter int unsigned           NUM_PORTS  = 12,
  parameter int unsigned           SEL_WIDTH  = 4,
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           TIMEOUT    = 255
) (
  input  logic                 pclk,
  input  logic                 preset_n,
  input  logic                 shadow_wr_en,
  input  logic [3:0]           shadow_wr_idx,
  input  logic [SEL_WIDTH-1:0] shadow_wr_data,
  output logic                 shadow_wr_rdy,
  input  logic                 commit,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [3:0]           err_idx,
  crossbar_route_committer_if.master apb
);

  localparam int unsigned NUM_ENT = NUM_PORTS + 2;
  localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_SETUP, S_ACCESS, S_RSETUP, S_RACCESS, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SEL_WIDTH-1:0] tbl_q [NUM_ENT];
  logic [SEL_WIDTH-1:0] tbl_d [NUM_ENT];
  logic [NUM_ENT-1:0]   dirty_q, dirty_d;
  logic                 err_q, err_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [3:0]           err_idx_q, err_idx_d;

  logic in_setup, in_access, in_xfer, is_write;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      tbl_q      <= '{default: '0};
      dirty_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      tbl_q      <= tbl_d;
      dirty_q    <= dirty_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      err_idx_q  <= err_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tbl_d      = tbl_q;
    dirty_d    = dirty_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    err_idx_d  = err_idx_q;

    if (shadow_wr_en && state_q == S_IDLE && 32'(shadow_wr_idx) < NUM_ENT) begin
      tbl_d[shadow_wr_idx]   = shadow_wr_data;
      dirty_d[shadow_wr_idx] = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (commit) begin
          state_d    = S_SCAN;
          idx_d      = '0;
          err_d      = 1'b0;
          err_code_d = '0;
          err_idx_d  = '0;
        end
      end
      S_SCAN: begin
        if (32'(idx_q) >= NUM_ENT) begin
          state_d = S_DONE;
        end else if (dirty_q[idx_q]) begin
          state_d = S_SETUP;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_SETUP, S_RSETUP: begin
        cnt_d   = '0;
        state_d = (state_q == S_SETUP) ? S_ACCESS : S_RACCESS;
      end
      S_ACCESS, S_RACCESS: begin
        // Write and read-back access share completion handling; only the verify build
        // diverts a finished write into the read phase.
        if (apb.pready) begin
          if (apb.pslverr) begin
            err_d = 1'b1; err_code_d = 2'b01; err_idx_d = idx_q; state_d = S_DONE;
          end
`ifdef CROSSBAR_COMMIT_VERIFY_EN
          else if (state_q == S_ACCESS) begin
            state_d = S_RSETUP;
          end else if (apb.prdata != 32'(tbl_q[idx_q])) begin
            err_d = 1'b1; err_code_d = 2'b11; err_idx_d = idx_q; state_d = S_DONE;
          end
`endif
          else begin
            dirty_d[idx_q] = 1'b0;
            idx_d          = idx_q + 4'd1;
            state_d        = S_SCAN;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d = 1'b1; err_code_d = 2'b10; err_idx_d = idx_q; state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifndef CROSSBAR_COMMIT_VERIFY_EN
  logic unused_prdata;
  assign unused_prdata = ^apb.prdata;
`endif

  assign in_setup  = (state_q == S_SETUP)  || (state_q == S_RSETUP);
  assign in_access = (state_q == S_ACCESS) || (state_q == S_RACCESS);
  assign in_xfer   = in_setup || in_access;
  assign is_write  = (state_q == S_SETUP)  || (state_q == S_ACCESS);

  assign apb.psel    = in_xfer;
  assign apb.penable = in_access;
  assign apb.pwrite  = is_write;
  assign apb.paddr   = in_xfer ? BASE_ADDR + ADDR_WIDTH'({idx_q, 5'b0}) : '0;
  assign apb.pwdata  = is_write ? 32'(tbl_q[idx_q]) : '0;

  assign shadow_wr_rdy = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign err_idx       = err_idx_q;

endmodule

// File: tb/tb_crossbar_route_committer.sv
// Directed bench for crossbar_route_committer with a small APB completer model.
module tb_crossbar_route_committer;

  logic       pclk = 1'b0;
  logic       preset_n = 1'b0;
  logic       shadow_wr_en = 1'b0;
  logic [3:0] shadow_wr_idx = '0;
  logic [3:0] shadow_wr_data = '0;
  logic       shadow_wr_rdy;
  logic       commit = 1'b0;
  logic       busy, done, err;
  logic [1:0] err_code;
  logic [3:0] err_idx;

  crossbar_route_committer_if #(.ADDR_WIDTH(16)) apb ();

  crossbar_route_committer #(
    .NUM_PORTS(12), .SEL_WIDTH(4), .ADDR_WIDTH(16), .BASE_ADDR(16'h0000), .TIMEOUT(255)
  ) dut (
    .pclk(pclk), .preset_n(preset_n),
    .shadow_wr_en(shadow_wr_en), .shadow_wr_idx(shadow_wr_idx),
    .shadow_wr_data(shadow_wr_data), .shadow_wr_rdy(shadow_wr_rdy),
    .commit(commit), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .err_idx(err_idx), .apb(apb)
  );

  always #5 pclk = ~pclk;

  // Completer configuration, driven by the stimulus block
  int          cfg_wait = 0;
  logic        cfg_hang = 1'b0;
  logic        cfg_err_en = 1'b0;
  logic [15:0] cfg_err_addr = '0;
  logic        cfg_bad_rd = 1'b0;

  int          wcnt;
  logic [31:0] mem [16];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  logic [31:0] log_err  [$];
  int          acc_cycles = 0;
  int          wait_seen = 0;
  int          unstable = 0;
  logic        hold_pending = 1'b0;
  logic [15:0] h_addr;
  logic [31:0] h_data;
  logic        h_wr;

  assign apb.pready  = apb.psel && apb.penable && !cfg_hang && (wcnt >= cfg_wait);
  assign apb.pslverr = apb.pready && cfg_err_en && apb.pwrite && (apb.paddr == cfg_err_addr);
  assign apb.prdata  = cfg_bad_rd ? 32'd4 : mem[apb.paddr[8:5]];

  always @(posedge pclk or negedge preset_n) begin
    if (!preset_n) wcnt <= 0;
    else if (apb.psel && apb.penable && !apb.pready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge pclk) begin
    if (apb.psel && apb.penable) acc_cycles <= acc_cycles + 1;
    if (apb.psel && apb.penable && !apb.pready && apb.pwrite) wait_seen <= wait_seen + 1;
    if (hold_pending && (apb.paddr != h_addr || apb.pwdata != h_data || apb.pwrite != h_wr
                         || !apb.psel || !apb.penable))
      unstable <= unstable + 1;
    hold_pending <= apb.psel && apb.penable && !apb.pready && preset_n;
    h_addr <= apb.paddr;
    h_data <= apb.pwdata;
    h_wr   <= apb.pwrite;
    if (apb.psel && apb.penable && apb.pready && apb.pwrite) begin
      log_addr.push_back(32'(apb.paddr));
      log_data.push_back(apb.pwdata);
      log_err.push_back(32'(apb.pslverr));
      if (!apb.pslverr) mem[apb.paddr[8:5]] <= apb.pwdata;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic shadow_write(input int idx, input int val);
    @(negedge pclk);
    shadow_wr_en   = 1'b1;
    shadow_wr_idx  = 4'(idx);
    shadow_wr_data = 4'(val);
    @(negedge pclk);
    shadow_wr_en   = 1'b0;
  endtask

  task automatic start_commit();
    @(negedge pclk);
    commit = 1'b1;
    @(negedge pclk);
    commit = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int  cyc;
    bit  ok;
    cyc = 0;
    ok  = 1'b0;
    while (cyc < limit && !ok) begin
      if (done) ok = 1'b1;
      else begin
        @(negedge pclk);
        cyc++;
      end
    end
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic after_done(input string tag);
    @(negedge pclk);
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  int base;
  int acc0;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state
    #12;
    check("rst_wr_rdy", 32'(shadow_wr_rdy), 32'd1);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_err",    {29'd0, err, err_code}, 32'd0);
    check("rst_psel",   {30'd0, apb.psel, apb.penable}, 32'd0);
    check("rst_paddr",  32'(apb.paddr), 32'd0);
    check("rst_pwdata", apb.pwdata, 32'd0);
    @(negedge pclk);
    preset_n = 1'b1;

    // Commit with nothing dirty
    base = log_addr.size();
    acc0 = acc_cycles;
    start_commit();
    check("empty_busy", 32'(busy), 32'd1);
    check("empty_wr_rdy", 32'(shadow_wr_rdy), 32'd0);
    wait_done("empty", 30);
    check("empty_err", 32'(err), 32'd0);
    after_done("empty");
    check("empty_no_psel", 32'(acc_cycles - acc0), 32'd0);
    check("empty_no_writes", 32'(log_addr.size() - base), 32'd0);

    // Two dirty entries, zero-wait completer
    shadow_write(3, 5);
    shadow_write(13, 0);
    base = log_addr.size();
    start_commit();
    wait_done("two", 100);
    check("two_err", 32'(err), 32'd0);
    after_done("two");
    check("two_count", 32'(log_addr.size() - base), 32'd2);
    if (log_addr.size() - base == 2) begin
      check("two_addr0", log_addr[base],   32'h060);
      check("two_data0", log_data[base],   32'd5);
      check("two_addr1", log_addr[base+1], 32'h1A0);
      check("two_data1", log_data[base+1], 32'd0);
    end

    // Dirty bits cleared by the successful commit
    base = log_addr.size();
    start_commit();
    wait_done("clean", 30);
    after_done("clean");
    check("clean_no_writes", 32'(log_addr.size() - base), 32'd0);

    // Wait states on idx3; a shadow write while busy must be ignored
    cfg_wait = 4;
    shadow_write(3, 7);
    base = log_addr.size();
    start_commit();
    shadow_wr_en = 1'b1; shadow_wr_idx = 4'd2; shadow_wr_data = 4'd6;
    @(negedge pclk);
    shadow_wr_en = 1'b0;
    wait_done("wait", 100);
    check("wait_err", 32'(err), 32'd0);
    after_done("wait");
    check("wait_stable", 32'(unstable), 32'd0);
    check("wait_cycles", 32'(wait_seen), 32'd4);
    check("wait_count", 32'(log_addr.size() - base), 32'd1);
    if (log_addr.size() - base == 1) begin
      check("wait_addr", log_addr[base], 32'h060);
      check("wait_data", log_data[base], 32'd7);
    end
    cfg_wait = 0;

    // Out-of-range index dropped, busy-time write did not stick
    shadow_write(14, 3);
    shadow_write(15, 9);
    base = log_addr.size();
    start_commit();
    wait_done("drop", 30);
    after_done("drop");
    check("drop_no_writes", 32'(log_addr.size() - base), 32'd0);

    // Slave error on idx3 stops the commit; retry writes both entries
    shadow_write(3, 9);
    shadow_write(13, 2);
    cfg_err_en = 1'b1; cfg_err_addr = 16'h060;
    base = log_addr.size();
    start_commit();
    wait_done("slverr", 100);
    check("slverr_err",  {28'd0, err, err_code, 1'b0}, {28'd0, 1'b1, 2'b01, 1'b0});
    check("slverr_idx",  32'(err_idx), 32'd3);
    after_done("slverr");
    check("slverr_count", 32'(log_addr.size() - base), 32'd1);
    cfg_err_en = 1'b0;
    base = log_addr.size();
    start_commit();
    @(negedge pclk);
    check("retry_err_cleared", 32'(err), 32'd0);
    wait_done("retry", 100);
    after_done("retry");
    check("retry_count", 32'(log_addr.size() - base), 32'd2);
    if (log_addr.size() - base == 2) begin
      check("retry_addr0", log_addr[base],   32'h060);
      check("retry_data0", log_data[base],   32'd9);
      check("retry_addr1", log_addr[base+1], 32'h1A0);
      check("retry_data1", log_data[base+1], 32'd2);
    end

    // Completer never ready: timeout after 255 ACCESS cycles
    cfg_hang = 1'b1;
    shadow_write(5, 1);
    acc0 = acc_cycles;
    start_commit();
    wait_done("tmo", 400);
    check("tmo_err",  {29'd0, err, err_code}, {29'd0, 1'b1, 2'b10});
    check("tmo_idx",  32'(err_idx), 32'd5);
    check("tmo_psel", 32'(apb.psel), 32'd0);
    check("tmo_acc_cycles", 32'(acc_cycles - acc0), 32'd255);
    after_done("tmo");
    cfg_hang = 1'b0;
    base = log_addr.size();
    start_commit();
    wait_done("tmo_retry", 100);
    after_done("tmo_retry");
    check("tmo_retry_count", 32'(log_addr.size() - base), 32'd1);
    if (log_addr.size() - base == 1) check("tmo_retry_addr", log_addr[base], 32'h0A0);

    // Reset in the middle of a transfer
    cfg_hang = 1'b1;
    shadow_write(4, 3);
    start_commit();
    repeat (5) @(negedge pclk);
    check("mid_psel_before", 32'(apb.psel), 32'd1);
    #2 preset_n = 1'b0;
    #1;
    check("mid_rst_apb", {30'd0, apb.psel, apb.penable}, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge pclk);
    check("mid_rst_done", 32'(done), 32'd0);
    preset_n = 1'b1;
    cfg_hang = 1'b0;
    base = log_addr.size();
    start_commit();
    wait_done("post_rst", 30);
    after_done("post_rst");
    check("post_rst_no_writes", 32'(log_addr.size() - base), 32'd0);

`ifdef CROSSBAR_COMMIT_VERIFY_EN
    // Read-back returns 4 where 5 was written
    cfg_bad_rd = 1'b1;
    shadow_write(3, 5);
    start_commit();
    wait_done("verify", 100);
    check("verify_err", {29'd0, err, err_code}, {29'd0, 1'b1, 2'b11});
    check("verify_idx", 32'(err_idx), 32'd3);
    after_done("verify");
    cfg_bad_rd = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
